itcm_ctrl: RTL and testbench
============================

Name: itcm_ctrl

Overview:
Instruction TCM controller sitting directly downstream of the IFU fetch interface (ifu2itcm_*) and in front of a single-port synchronous SRAM macro. Arbitrates between the IFU (read-only) and the LSU (read/write) command ports and issues at most one SRAM access per cycle. Returns each port's response after 1-cycle SRAM latency, holding data locally under response backpressure. Sustains one fetch per cycle when uncontended and rsp_ready is high.

Parameters:
ITCM_ADDR_WIDTH, 16, byte address width of both command ports
ITCM_RAM_DW, 32, SRAM data width (bits)
ITCM_RAM_AW, ITCM_ADDR_WIDTH-2, SRAM word address width (derived)

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
ifu2itcm_cmd_valid  in  1  IFU fetch request valid
ifu2itcm_cmd_ready  out  1  IFU request accepted
ifu2itcm_cmd_addr  in  ITCM_ADDR_WIDTH  IFU byte address
ifu2itcm_rsp_valid  out  1  IFU response valid
ifu2itcm_rsp_ready  in  1  IFU response accepted
ifu2itcm_rsp_rdata  out  ITCM_RAM_DW  fetched word
lsu2itcm_cmd_valid  in  1  LSU request valid
lsu2itcm_cmd_ready  out  1  LSU request accepted
lsu2itcm_cmd_addr  in  ITCM_ADDR_WIDTH  LSU byte address
lsu2itcm_cmd_read  in  1  1=read, 0=write
lsu2itcm_cmd_wdata  in  ITCM_RAM_DW  write data
lsu2itcm_cmd_wmask  in  ITCM_RAM_DW/8  byte write enables
lsu2itcm_rsp_valid  out  1  LSU response valid
lsu2itcm_rsp_ready  in  1  LSU response accepted
lsu2itcm_rsp_rdata  out  ITCM_RAM_DW  read data (0 for writes)
ram_cs  out  1  SRAM chip select
ram_we  out  1  SRAM write enable
ram_addr  out  ITCM_RAM_AW  SRAM word address
ram_wem  out  ITCM_RAM_DW/8  SRAM byte write mask
ram_din  out  ITCM_RAM_DW  SRAM write data
ram_dout  in  ITCM_RAM_DW  SRAM read data, valid the cycle after ram_cs

Behaviour:
- Clock clk; reset rst_n is synchronous, active-low. While rst_n=0: both cmd_ready=0, ram_cs=0; registers cleared on the clock edge.
- Per-port response slot, states EMPTY, PEND (access issued last cycle; data on ram_dout now), HOLD (data in local hold register). Reset: EMPTY, hold register 0, is_write flag 0.
- rsp_valid = (PEND|HOLD); rsp_rdata = PEND ? (is_write ? 0 : ram_dout) : hold_q; rsp_rdata = 0 when EMPTY.
- Port eligible = EMPTY, or (PEND|HOLD) and rsp_ready (slot drains this cycle). A port in PEND/HOLD with rsp_ready=0 is never granted.
- Arbitration: only one eligible port valid -> grant it. Both -> round-robin pointer rr (reset 0 = IFU preferred); rr flips to the losing port after every contended cycle and is unchanged otherwise.
- cmd_ready = grant for that port (combinational; cmd_ready may depend on cmd_valid of the other port). Handshake = valid & ready.
- On handshake: ram_cs=1, ram_addr=cmd_addr[ITCM_ADDR_WIDTH-1:2] (bits [1:0] ignored, no misalignment error); LSU write: ram_we=1, ram_wem=wmask, ram_din=wdata. Otherwise ram_we=0, ram_wem=0, ram_din=0.
- Slot transitions: EMPTY->PEND on handshake. PEND: rsp_ready & handshake -> PEND; rsp_ready & no handshake -> EMPTY; !rsp_ready -> HOLD, capturing ram_dout (or 0 if write). HOLD: rsp_ready -> PEND if handshake else EMPTY; else stay.
- Latency: response 1 cycle after command handshake. Throughput 1/cycle per port when uncontended; a port under sustained backpressure blocks only itself.
- Responses are strictly in-order per port; at most one outstanding per port.
- Reset mid-operation discards PEND/HOLD data; no response is produced after reset deasserts.

Decomposition:
- Shared defines: ITCM_ADDR_WIDTH, ITCM_RAM_DW, slot state encodings (EMPTY=2'd0, PEND=2'd1, HOLD=2'd2).
- Sub-module itcm_rsp_slot (state, hold register, is_write flag, eligibility output), instanced once per port; arbiter and SRAM muxing live in itcm_ctrl.

Test Plan:
- IFU-only streaming: addrs 0x0,0x4,0x8 back-to-back, rsp_ready=1, RAM words 0x00000013/0x00100093/0x00200113 -> rsp_valid on cycles 1..3, data in order, cmd_ready held 1.
- IFU backpressure: fetch 0x10 (word 0xDEADBEEF), rsp_ready=0 for 3 cycles -> slot HOLD, rdata stays 0xDEADBEEF, ifu cmd_ready=0; rsp_ready=1 with new cmd -> drained and new read issued same cycle.
- Contention: both valid 4 cycles, all slots draining -> grants IFU, LSU, IFU, LSU; rr flips each cycle.
- LSU write then IFU read: write 0x20 data 0xAABBCCDD mask 4'b0011, then IFU fetch 0x20 over prior 0x11223344 -> LSU rsp_rdata 0, IFU gets 0x1122CCDD.
- Address low bits: IFU addr 0x22 -> ram_addr 0x8.
- Reset mid-op: IFU slot in HOLD, rst_n=0 one cycle -> rsp_valid=0, cmd_ready=0 during reset; after release, slots EMPTY, rr=0, no stale response.

Source files
------------

// File: rtl/itcm_ctrl_pkg.sv
// Shared widths and response-slot encodings for the instruction TCM controller.
package itcm_ctrl_pkg;

  localparam int ITCM_ADDR_WIDTH = 16;
  localparam int ITCM_RAM_DW     = 32;
  localparam int ITCM_RAM_AW     = ITCM_ADDR_WIDTH - 2;
  localparam int ITCM_RAM_MW     = ITCM_RAM_DW / 8;

  typedef enum logic [1:0] {
    SLOT_EMPTY = 2'd0,
    SLOT_PEND  = 2'd1,
    SLOT_HOLD  = 2'd2
  } slot_state_e;

endpackage

// File: rtl/itcm_rsp_slot.sv
// Per-port response slot: tracks one outstanding SRAM access and parks its data
// locally while the consumer is not ready.
//
// state | meaning
// EMPTY | nothing outstanding
// PEND  | access issued last cycle, data is on ram_dout now
// HOLD  | data captured in the hold register, waiting for rsp_ready
module itcm_rsp_slot
  import itcm_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_hsk,
  input  logic                   i_hsk_write,
  input  logic                   i_rsp_ready,
  input  logic [ITCM_RAM_DW-1:0] i_ram_dout,
  output logic                   o_rsp_valid,
  output logic [ITCM_RAM_DW-1:0] o_rsp_rdata,
  output logic                   o_eligible
);

  slot_state_e            r_state;
  slot_state_e            w_state_nxt;
  logic [ITCM_RAM_DW-1:0] r_hold;
  logic [ITCM_RAM_DW-1:0] w_hold_nxt;
  logic                   r_is_write;
  logic                   w_is_write_nxt;
  logic [ITCM_RAM_DW-1:0] w_pend_data;

  assign w_pend_data = r_is_write ? '0 : i_ram_dout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= SLOT_EMPTY;
      r_hold     <= '0;
      r_is_write <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold     <= w_hold_nxt;
      r_is_write <= w_is_write_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_hold_nxt     = r_hold;
    w_is_write_nxt = r_is_write;
    case (r_state)
      SLOT_EMPTY: begin
        if (i_hsk) begin
          w_state_nxt    = SLOT_PEND;
          w_is_write_nxt = i_hsk_write;
        end
      end
      SLOT_PEND: begin
        if (i_rsp_ready) begin
          if (i_hsk) begin
            w_state_nxt    = SLOT_PEND;
            w_is_write_nxt = i_hsk_write;
          end else begin
            w_state_nxt = SLOT_EMPTY;
          end
        end else begin
          // SRAM output is only valid for one cycle, so park it here.
          w_state_nxt = SLOT_HOLD;
          w_hold_nxt  = w_pend_data;
        end
      end
      SLOT_HOLD: begin
        if (i_rsp_ready) begin
          if (i_hsk) begin
            w_state_nxt    = SLOT_PEND;
            w_is_write_nxt = i_hsk_write;
          end else begin
            w_state_nxt = SLOT_EMPTY;
          end
        end
      end
      default: w_state_nxt = SLOT_EMPTY;
    endcase
  end

  always_comb begin
    o_rsp_valid = rst_n && ((r_state == SLOT_PEND) || (r_state == SLOT_HOLD));
    o_rsp_rdata = '0;
    if (o_rsp_valid) begin
      o_rsp_rdata = (r_state == SLOT_PEND) ? w_pend_data : r_hold;
    end
    o_eligible = (r_state == SLOT_EMPTY) || i_rsp_ready;
  end

endmodule

// File: rtl/itcm_ctrl.sv
// ITCM controller: round-robin arbitration of IFU and LSU onto one single-port
// SRAM, with a response slot per port to absorb backpressure.
module itcm_ctrl
  import itcm_ctrl_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ifu2itcm_cmd_valid,
  output logic                       ifu2itcm_cmd_ready,
  input  logic [ITCM_ADDR_WIDTH-1:0] ifu2itcm_cmd_addr,
  output logic                       ifu2itcm_rsp_valid,
  input  logic                       ifu2itcm_rsp_ready,
  output logic [ITCM_RAM_DW-1:0]     ifu2itcm_rsp_rdata,
  input  logic                       lsu2itcm_cmd_valid,
  output logic                       lsu2itcm_cmd_ready,
  input  logic [ITCM_ADDR_WIDTH-1:0] lsu2itcm_cmd_addr,
  input  logic                       lsu2itcm_cmd_read,
  input  logic [ITCM_RAM_DW-1:0]     lsu2itcm_cmd_wdata,
  input  logic [ITCM_RAM_MW-1:0]     lsu2itcm_cmd_wmask,
  output logic                       lsu2itcm_rsp_valid,
  input  logic                       lsu2itcm_rsp_ready,
  output logic [ITCM_RAM_DW-1:0]     lsu2itcm_rsp_rdata,
  output logic                       ram_cs,
  output logic                       ram_we,
  output logic [ITCM_RAM_AW-1:0]     ram_addr,
  output logic [ITCM_RAM_MW-1:0]     ram_wem,
  output logic [ITCM_RAM_DW-1:0]     ram_din,
  input  logic [ITCM_RAM_DW-1:0]     ram_dout
);

  logic r_rr;
  logic w_ifu_elig;
  logic w_lsu_elig;
  logic w_ifu_req;
  logic w_lsu_req;
  logic w_ifu_gnt;
  logic w_lsu_gnt;
  logic w_contend;
  logic w_lsu_wr;
  logic w_unused;

  // Byte offset within the word is ignored; misaligned addresses just alias.
  assign w_unused = ^{ifu2itcm_cmd_addr[1:0], lsu2itcm_cmd_addr[1:0]};

  assign w_ifu_req = ifu2itcm_cmd_valid && w_ifu_elig;
  assign w_lsu_req = lsu2itcm_cmd_valid && w_lsu_elig;
  assign w_contend = rst_n && w_ifu_req && w_lsu_req;

  always_comb begin
    w_ifu_gnt = 1'b0;
    w_lsu_gnt = 1'b0;
    if (rst_n) begin
      if (w_ifu_req && w_lsu_req) begin
        w_ifu_gnt = !r_rr;
        w_lsu_gnt = r_rr;
      end else begin
        w_ifu_gnt = w_ifu_req;
        w_lsu_gnt = w_lsu_req;
      end
    end
  end

  // r_rr names the preferred port (0 = IFU); it moves to the loser on contention.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr <= 1'b0;
    end else if (w_contend) begin
      r_rr <= !r_rr;
    end
  end

  assign ifu2itcm_cmd_ready = w_ifu_gnt;
  assign lsu2itcm_cmd_ready = w_lsu_gnt;
  assign w_lsu_wr           = w_lsu_gnt && !lsu2itcm_cmd_read;

  always_comb begin
    ram_cs   = w_ifu_gnt || w_lsu_gnt;
    ram_we   = w_lsu_wr;
    ram_addr = '0;
    ram_wem  = '0;
    ram_din  = '0;
    if (w_lsu_gnt) begin
      ram_addr = lsu2itcm_cmd_addr[ITCM_ADDR_WIDTH-1:2];
    end else if (w_ifu_gnt) begin
      ram_addr = ifu2itcm_cmd_addr[ITCM_ADDR_WIDTH-1:2];
    end
    if (w_lsu_wr) begin
      ram_wem = lsu2itcm_cmd_wmask;
      ram_din = lsu2itcm_cmd_wdata;
    end
  end

  itcm_rsp_slot u_ifu_slot (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_hsk       (w_ifu_gnt),
    .i_hsk_write (1'b0),
    .i_rsp_ready (ifu2itcm_rsp_ready),
    .i_ram_dout  (ram_dout),
    .o_rsp_valid (ifu2itcm_rsp_valid),
    .o_rsp_rdata (ifu2itcm_rsp_rdata),
    .o_eligible  (w_ifu_elig)
  );

  itcm_rsp_slot u_lsu_slot (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_hsk       (w_lsu_gnt),
    .i_hsk_write (w_lsu_wr),
    .i_rsp_ready (lsu2itcm_rsp_ready),
    .i_ram_dout  (ram_dout),
    .o_rsp_valid (lsu2itcm_rsp_valid),
    .o_rsp_rdata (lsu2itcm_rsp_rdata),
    .o_eligible  (w_lsu_elig)
  );

endmodule

// File: tb/tb_itcm_ctrl.sv
// Bench for itcm_ctrl: behavioural SRAM, reference memory and per-port
// response queues, plus scenario tasks with inline checks.
module tb_itcm_ctrl;
  import itcm_ctrl_pkg::*;

  logic                       clk;
  logic                       rst_n;
  logic                       ifu2itcm_cmd_valid;
  logic                       ifu2itcm_cmd_ready;
  logic [ITCM_ADDR_WIDTH-1:0] ifu2itcm_cmd_addr;
  logic                       ifu2itcm_rsp_valid;
  logic                       ifu2itcm_rsp_ready;
  logic [ITCM_RAM_DW-1:0]     ifu2itcm_rsp_rdata;
  logic                       lsu2itcm_cmd_valid;
  logic                       lsu2itcm_cmd_ready;
  logic [ITCM_ADDR_WIDTH-1:0] lsu2itcm_cmd_addr;
  logic                       lsu2itcm_cmd_read;
  logic [ITCM_RAM_DW-1:0]     lsu2itcm_cmd_wdata;
  logic [ITCM_RAM_MW-1:0]     lsu2itcm_cmd_wmask;
  logic                       lsu2itcm_rsp_valid;
  logic                       lsu2itcm_rsp_ready;
  logic [ITCM_RAM_DW-1:0]     lsu2itcm_rsp_rdata;
  logic                       ram_cs;
  logic                       ram_we;
  logic [ITCM_RAM_AW-1:0]     ram_addr;
  logic [ITCM_RAM_MW-1:0]     ram_wem;
  logic [ITCM_RAM_DW-1:0]     ram_din;
  logic [ITCM_RAM_DW-1:0]     ram_dout;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem     [0:16383];
  logic [31:0] ref_mem [0:16383];
  logic [31:0] ifu_q[$];
  logic [31:0] lsu_q[$];

  itcm_ctrl dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .ifu2itcm_cmd_valid (ifu2itcm_cmd_valid),
    .ifu2itcm_cmd_ready (ifu2itcm_cmd_ready),
    .ifu2itcm_cmd_addr  (ifu2itcm_cmd_addr),
    .ifu2itcm_rsp_valid (ifu2itcm_rsp_valid),
    .ifu2itcm_rsp_ready (ifu2itcm_rsp_ready),
    .ifu2itcm_rsp_rdata (ifu2itcm_rsp_rdata),
    .lsu2itcm_cmd_valid (lsu2itcm_cmd_valid),
    .lsu2itcm_cmd_ready (lsu2itcm_cmd_ready),
    .lsu2itcm_cmd_addr  (lsu2itcm_cmd_addr),
    .lsu2itcm_cmd_read  (lsu2itcm_cmd_read),
    .lsu2itcm_cmd_wdata (lsu2itcm_cmd_wdata),
    .lsu2itcm_cmd_wmask (lsu2itcm_cmd_wmask),
    .lsu2itcm_rsp_valid (lsu2itcm_rsp_valid),
    .lsu2itcm_rsp_ready (lsu2itcm_rsp_ready),
    .lsu2itcm_rsp_rdata (lsu2itcm_rsp_rdata),
    .ram_cs             (ram_cs),
    .ram_we             (ram_we),
    .ram_addr           (ram_addr),
    .ram_wem            (ram_wem),
    .ram_din            (ram_din),
    .ram_dout           (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model; write cycles put garbage on dout so write responses must be masked.
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) begin
        for (int b = 0; b < ITCM_RAM_MW; b++) begin
          if (ram_wem[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
        end
        ram_dout <= $urandom();
      end else begin
        ram_dout <= mem[ram_addr];
      end
    end
  end

  // Scoreboard: push expected data at handshake, pop at response.
  always @(negedge clk) begin
    logic [31:0] exp_v;
    if (!rst_n) begin
      ifu_q.delete();
      lsu_q.delete();
    end else begin
      if (ifu2itcm_rsp_valid && ifu2itcm_rsp_ready) begin
        checks++;
        if (ifu_q.size() == 0) begin
          errors++;
          $display("FAIL ifu_unexpected_rsp got=%h expected=none", ifu2itcm_rsp_rdata);
        end else begin
          exp_v = ifu_q.pop_front();
          if (ifu2itcm_rsp_rdata !== exp_v) begin
            errors++;
            $display("FAIL ifu_rsp_data got=%h expected=%h", ifu2itcm_rsp_rdata, exp_v);
          end
        end
      end
      if (lsu2itcm_rsp_valid && lsu2itcm_rsp_ready) begin
        checks++;
        if (lsu_q.size() == 0) begin
          errors++;
          $display("FAIL lsu_unexpected_rsp got=%h expected=none", lsu2itcm_rsp_rdata);
        end else begin
          exp_v = lsu_q.pop_front();
          if (lsu2itcm_rsp_rdata !== exp_v) begin
            errors++;
            $display("FAIL lsu_rsp_data got=%h expected=%h", lsu2itcm_rsp_rdata, exp_v);
          end
        end
      end
      if (ifu2itcm_cmd_valid && ifu2itcm_cmd_ready)
        ifu_q.push_back(ref_mem[ifu2itcm_cmd_addr[15:2]]);
      if (lsu2itcm_cmd_valid && lsu2itcm_cmd_ready) begin
        if (lsu2itcm_cmd_read) begin
          lsu_q.push_back(ref_mem[lsu2itcm_cmd_addr[15:2]]);
        end else begin
          for (int b = 0; b < 4; b++) begin
            if (lsu2itcm_cmd_wmask[b])
              ref_mem[lsu2itcm_cmd_addr[15:2]][8*b +: 8] = lsu2itcm_cmd_wdata[8*b +: 8];
          end
          lsu_q.push_back(32'h0);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    mem[idx]     = val;
    ref_mem[idx] = val;
  endtask

  task automatic idle_inputs();
    ifu2itcm_cmd_valid = 1'b0;
    ifu2itcm_cmd_addr  = '0;
    lsu2itcm_cmd_valid = 1'b0;
    lsu2itcm_cmd_addr  = '0;
    lsu2itcm_cmd_read  = 1'b1;
    lsu2itcm_cmd_wdata = '0;
    lsu2itcm_cmd_wmask = '0;
    ifu2itcm_rsp_ready = 1'b1;
    lsu2itcm_rsp_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    ifu2itcm_cmd_valid = 1'b1;
    lsu2itcm_cmd_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({ifu2itcm_cmd_ready, lsu2itcm_cmd_ready, ram_cs} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ready_cs got=%b expected=000",
               {ifu2itcm_cmd_ready, lsu2itcm_cmd_ready, ram_cs});
    end
    next_cycle();
    idle_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({ifu2itcm_rsp_valid, lsu2itcm_rsp_valid} !== 2'b00 ||
        ifu2itcm_rsp_rdata !== 32'h0 || lsu2itcm_rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rsp got_valid=%b got_ifu=%h got_lsu=%h expected=0",
               {ifu2itcm_rsp_valid, lsu2itcm_rsp_valid}, ifu2itcm_rsp_rdata, lsu2itcm_rsp_rdata);
    end
    next_cycle();
  endtask

  task automatic test_ifu_stream();
    for (int i = 0; i < 4; i++) begin
      ifu2itcm_cmd_valid = (i < 3);
      ifu2itcm_cmd_addr  = 16'(i * 4);
      @(negedge clk);
      checks++;
      if (ifu2itcm_rsp_valid !== (i > 0)) begin
        errors++;
        $display("FAIL stream_rsp_valid cycle=%0d got=%b expected=%b", i, ifu2itcm_rsp_valid, i > 0);
      end
      if (i < 3) begin
        checks++;
        if (ifu2itcm_cmd_ready !== 1'b1 || ram_addr !== 14'(i)) begin
          errors++;
          $display("FAIL stream_issue cycle=%0d got_ready=%b got_addr=%h expected=1/%h",
                   i, ifu2itcm_cmd_ready, ram_addr, i);
        end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_ifu_backpressure();
    ifu2itcm_rsp_ready = 1'b0;
    ifu2itcm_cmd_valid = 1'b1;
    ifu2itcm_cmd_addr  = 16'h0010;
    @(negedge clk);
    checks++;
    if (ifu2itcm_cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_first_ready got=%b expected=1", ifu2itcm_cmd_ready);
    end
    next_cycle();
    ifu2itcm_cmd_addr = 16'h0014;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (ifu2itcm_cmd_ready !== 1'b0 || ifu2itcm_rsp_valid !== 1'b1 ||
          ifu2itcm_rsp_rdata !== 32'hDEADBEEF) begin
        errors++;
        $display("FAIL bp_hold k=%0d got_ready=%b got_valid=%b got_data=%h expected=0/1/deadbeef",
                 k, ifu2itcm_cmd_ready, ifu2itcm_rsp_valid, ifu2itcm_rsp_rdata);
      end
      next_cycle();
    end
    ifu2itcm_rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (ifu2itcm_cmd_ready !== 1'b1 || ifu2itcm_rsp_rdata !== 32'hDEADBEEF || ram_addr !== 14'h5) begin
      errors++;
      $display("FAIL bp_drain got_ready=%b got_data=%h got_addr=%h expected=1/deadbeef/0005",
               ifu2itcm_cmd_ready, ifu2itcm_rsp_rdata, ram_addr);
    end
    next_cycle();
    ifu2itcm_cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ifu2itcm_rsp_valid !== 1'b1 || ifu2itcm_rsp_rdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL bp_next got_valid=%b got_data=%h expected=1/cafef00d",
               ifu2itcm_rsp_valid, ifu2itcm_rsp_rdata);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_contention();
    logic exp_ifu;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ifu2itcm_cmd_valid = 1'b1;
      ifu2itcm_cmd_addr  = 16'(16'h0040 + i * 4);
      lsu2itcm_cmd_valid = 1'b1;
      lsu2itcm_cmd_read  = 1'b1;
      lsu2itcm_cmd_addr  = 16'(16'h0060 + i * 4);
      exp_ifu = (i % 2 == 0);
      @(negedge clk);
      checks++;
      if (ifu2itcm_cmd_ready !== exp_ifu || lsu2itcm_cmd_ready !== !exp_ifu || ram_cs !== 1'b1) begin
        errors++;
        $display("FAIL contention_grant cycle=%0d got_ifu=%b got_lsu=%b expected_ifu=%b",
                 i, ifu2itcm_cmd_ready, lsu2itcm_cmd_ready, exp_ifu);
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_write_then_read();
    lsu2itcm_cmd_valid = 1'b1;
    lsu2itcm_cmd_read  = 1'b0;
    lsu2itcm_cmd_addr  = 16'h0020;
    lsu2itcm_cmd_wdata = 32'hAABBCCDD;
    lsu2itcm_cmd_wmask = 4'b0011;
    @(negedge clk);
    checks++;
    if (lsu2itcm_cmd_ready !== 1'b1 || ram_we !== 1'b1 || ram_wem !== 4'b0011 ||
        ram_din !== 32'hAABBCCDD || ram_addr !== 14'h8) begin
      errors++;
      $display("FAIL write_issue got_rdy=%b we=%b wem=%b din=%h addr=%h expected=1/1/0011/aabbccdd/0008",
               lsu2itcm_cmd_ready, ram_we, ram_wem, ram_din, ram_addr);
    end
    next_cycle();
    idle_inputs();
    ifu2itcm_cmd_valid = 1'b1;
    ifu2itcm_cmd_addr  = 16'h0020;
    @(negedge clk);
    checks++;
    if (lsu2itcm_rsp_valid !== 1'b1 || lsu2itcm_rsp_rdata !== 32'h0 || ifu2itcm_cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL write_rsp got_valid=%b got_data=%h got_ifu_ready=%b expected=1/00000000/1",
               lsu2itcm_rsp_valid, lsu2itcm_rsp_rdata, ifu2itcm_cmd_ready);
    end
    next_cycle();
    ifu2itcm_cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ifu2itcm_rsp_rdata !== 32'h1122CCDD) begin
      errors++;
      $display("FAIL read_after_write got=%h expected=1122ccdd", ifu2itcm_rsp_rdata);
    end
    next_cycle();
  endtask

  task automatic test_addr_low_bits();
    ifu2itcm_cmd_valid = 1'b1;
    ifu2itcm_cmd_addr  = 16'h0022;
    @(negedge clk);
    checks++;
    if (ram_addr !== 14'h8 || ram_we !== 1'b0 || ram_wem !== 4'h0 || ram_din !== 32'h0) begin
      errors++;
      $display("FAIL addr_low_bits got_addr=%h we=%b wem=%b din=%h expected=0008/0/0/0",
               ram_addr, ram_we, ram_wem, ram_din);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    ifu2itcm_rsp_ready = 1'b0;
    ifu2itcm_cmd_valid = 1'b1;
    ifu2itcm_cmd_addr  = 16'h0004;
    lsu2itcm_cmd_valid = 1'b1;
    lsu2itcm_cmd_addr  = 16'h0000;
    @(negedge clk);
    checks++;
    if (ifu2itcm_cmd_ready !== 1'b1 || lsu2itcm_cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL midop_first_grant got_ifu=%b got_lsu=%b expected=1/0",
               ifu2itcm_cmd_ready, lsu2itcm_cmd_ready);
    end
    next_cycle();
    ifu2itcm_cmd_valid = 1'b0;
    lsu2itcm_cmd_valid = 1'b0;
    next_cycle();
    @(negedge clk);
    checks++;
    if (ifu2itcm_rsp_valid !== 1'b1 || ifu2itcm_rsp_rdata !== 32'h00100093) begin
      errors++;
      $display("FAIL midop_hold got_valid=%b got_data=%h expected=1/00100093",
               ifu2itcm_rsp_valid, ifu2itcm_rsp_rdata);
    end
    next_cycle();
    rst_n = 1'b0;
    ifu2itcm_cmd_valid = 1'b1;
    lsu2itcm_cmd_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({ifu2itcm_rsp_valid, lsu2itcm_rsp_valid, ifu2itcm_cmd_ready, lsu2itcm_cmd_ready, ram_cs} !== 5'b0) begin
      errors++;
      $display("FAIL midop_in_reset got=%b expected=00000",
               {ifu2itcm_rsp_valid, lsu2itcm_rsp_valid, ifu2itcm_cmd_ready, lsu2itcm_cmd_ready, ram_cs});
    end
    next_cycle();
    rst_n = 1'b1;
    idle_inputs();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if ({ifu2itcm_rsp_valid, lsu2itcm_rsp_valid} !== 2'b00) begin
        errors++;
        $display("FAIL midop_stale k=%0d got=%b expected=00", k, {ifu2itcm_rsp_valid, lsu2itcm_rsp_valid});
      end
      next_cycle();
    end
    ifu2itcm_cmd_valid = 1'b1;
    ifu2itcm_cmd_addr  = 16'h0008;
    lsu2itcm_cmd_valid = 1'b1;
    lsu2itcm_cmd_addr  = 16'h0000;
    @(negedge clk);
    checks++;
    if (ifu2itcm_cmd_ready !== 1'b1 || lsu2itcm_cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL midop_rr_reset got_ifu=%b got_lsu=%b expected=1/0",
               ifu2itcm_cmd_ready, lsu2itcm_cmd_ready);
    end
    next_cycle();
    idle_inputs();
    for (int k = 0; k < 3; k++) next_cycle();
  endtask

  initial begin
    ram_dout = '0;
    idle_inputs();
    rst_n = 1'b0;
    preload(0, 32'h00000013);
    preload(1, 32'h00100093);
    preload(2, 32'h00200113);
    preload(4, 32'hDEADBEEF);
    preload(5, 32'hCAFEF00D);
    preload(8, 32'h11223344);
    for (int i = 16; i < 32; i++) preload(i, 32'h10000000 + 32'(i) * 32'h01010101);
    next_cycle();

    test_reset();
    test_ifu_stream();
    test_ifu_backpressure();
    test_contention();
    test_write_then_read();
    test_addr_low_bits();
    test_reset_mid_op();

    @(negedge clk);
    checks++;
    if (ifu_q.size() != 0 || lsu_q.size() != 0) begin
      errors++;
      $display("FAIL missing_rsp got_ifu_left=%0d got_lsu_left=%0d expected=0/0", ifu_q.size(), lsu_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
